// File: rtl/cameralink_capture_ctl.sv
// Frame-capture sequencer for the SIMBUS CameraLink grabber side: requests a frame,
// syncs to a clean FVV start, and emits qualified pixels with x/y and geometry checks.
module cameralink_capture_ctl #(
  parameter int WIDTH   = 640,
  parameter int HEIGHT  = 480,
  parameter int XW      = 12,
  parameter int YW      = 12,
  parameter int TIMEOUT = 1000000
) (
  input  logic          CLOCK,
  input  logic          RESET_n,
  input  logic          start,
  input  logic          abort,
  input  logic          FVV,
  input  logic          LVV,
  input  logic          VCE,
  input  logic [7:0]    red,
  input  logic [7:0]    green,
  input  logic [7:0]    blue,
  output logic          cam_enable,
  output logic          cam_request,
  output logic          busy,
  output logic          done,
  output logic          err_size,
  output logic          err_timeout,
  output logic          pix_valid,
  output logic [23:0]   pix_data,
  output logic [XW-1:0] pix_x,
  output logic [YW-1:0] pix_y,
  output logic          pix_sof,
  output logic          pix_eof
);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [XW-1:0] W_X  = XW'(WIDTH);
  localparam logic [YW-1:0] H_Y  = YW'(HEIGHT);
  localparam logic [TW-1:0] TO_T = TW'(TIMEOUT);

  typedef enum logic [2:0] {IDLE, REQ, SYNC, WAIT_FV, CAPTURE, FINISH} state_t;

  state_t        state, state_d;
  logic [TW-1:0] tcnt, tcnt_d, tcnt_inc;
  logic [XW-1:0] x, x_d, pix_x_d;
  logic [YW-1:0] y, y_d, y_inc, lines, pix_y_d;
  logic          fvv_q, lvv_q, pixel;
  logic          err_size_d, err_timeout_d, pix_valid_d, pix_sof_d, pix_eof_d;
  logic [23:0]   pix_data_d;

  always_comb begin
    state_d       = state;
    tcnt_d        = tcnt;
    x_d           = x;
    y_d           = y;
    err_size_d    = err_size;
    err_timeout_d = err_timeout;
    pix_valid_d   = 1'b0;
    pix_sof_d     = 1'b0;
    pix_eof_d     = 1'b0;
    pix_data_d    = pix_data;
    pix_x_d       = pix_x;
    pix_y_d       = pix_y;
    pixel         = FVV & LVV & VCE;
    tcnt_inc      = tcnt + 1'b1;
    y_inc         = (y == '1) ? y : y + 1'b1;
    lines         = y;

    if (abort && state != IDLE) begin
      state_d = IDLE;
    end else begin
      case (state)
        IDLE: if (start && !abort) begin
          state_d       = REQ;
          err_size_d    = 1'b0;
          err_timeout_d = 1'b0;
        end
        REQ: begin
          tcnt_d  = '0;
          state_d = FVV ? SYNC : WAIT_FV;
        end
        SYNC: begin
          tcnt_d = tcnt_inc;
          if (!FVV) state_d = WAIT_FV;
          if (tcnt_inc == TO_T) begin
            state_d       = FINISH;
            err_timeout_d = 1'b1;
          end
        end
        WAIT_FV: begin
          // A frame start in the same cycle the budget runs out still wins.
          if (!fvv_q && FVV) begin
            state_d = CAPTURE;
            x_d     = '0;
            y_d     = '0;
          end else begin
            tcnt_d = tcnt_inc;
            if (tcnt_inc == TO_T) begin
              state_d       = FINISH;
              err_timeout_d = 1'b1;
            end
          end
        end
        CAPTURE: begin
          if (pixel) begin
            if (x < W_X && y < H_Y) begin
              pix_valid_d = 1'b1;
              pix_data_d  = {blue, green, red};
              pix_x_d     = x;
              pix_y_d     = y;
              pix_sof_d   = (x == '0) && (y == '0);
              pix_eof_d   = (x == W_X - 1'b1) && (y == H_Y - 1'b1);
            end else begin
              err_size_d = 1'b1;
            end
            if (x != '1) x_d = x + 1'b1;
          end
          if (fvv_q && !FVV) begin
            if (lvv_q) begin
              if (x != W_X) err_size_d = 1'b1;
              lines = y_inc;
            end
            if (lines != H_Y) err_size_d = 1'b1;
            state_d = FINISH;
          end else if (FVV && lvv_q && !LVV) begin
            if (x != W_X) err_size_d = 1'b1;
            x_d = '0;
            y_d = y_inc;
          end
        end
        FINISH:  state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLOCK or negedge RESET_n) begin
    if (!RESET_n) begin
      state       <= IDLE;
      tcnt        <= '0;
      x           <= '0;
      y           <= '0;
      fvv_q       <= 1'b0;
      lvv_q       <= 1'b0;
      cam_enable  <= 1'b0;
      cam_request <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err_size    <= 1'b0;
      err_timeout <= 1'b0;
      pix_valid   <= 1'b0;
      pix_data    <= '0;
      pix_x       <= '0;
      pix_y       <= '0;
      pix_sof     <= 1'b0;
      pix_eof     <= 1'b0;
    end else begin
      state       <= state_d;
      tcnt        <= tcnt_d;
      x           <= x_d;
      y           <= y_d;
      fvv_q       <= FVV;
      lvv_q       <= LVV;
      cam_enable  <= state_d inside {REQ, SYNC, WAIT_FV, CAPTURE};
      cam_request <= (state_d == REQ);
      busy        <= (state_d != IDLE);
      done        <= (state_d == FINISH);
      err_size    <= err_size_d;
      err_timeout <= err_timeout_d;
      pix_valid   <= pix_valid_d;
      pix_data    <= pix_data_d;
      pix_x       <= pix_x_d;
      pix_y       <= pix_y_d;
      pix_sof     <= pix_sof_d;
      pix_eof     <= pix_eof_d;
    end
  end
endmodule

// File: tb/tb_cameralink_capture_ctl.sv
// Randomized bench for cameralink_capture_ctl: each frame scenario derives its own
// expected outputs cycle by cycle; a negedge process compares them against the DUT.
module tb_cameralink_capture_ctl;
  localparam int W = 4, H = 3, XW = 4, YW = 4, TO = 20;

  logic          CLOCK, RESET_n, start, abort, FVV, LVV, VCE;
  logic [7:0]    red, green, blue;
  logic          cam_enable, cam_request, busy, done, err_size, err_timeout;
  logic          pix_valid, pix_sof, pix_eof;
  logic [23:0]   pix_data;
  logic [XW-1:0] pix_x;
  logic [YW-1:0] pix_y;

  cameralink_capture_ctl #(.WIDTH(W), .HEIGHT(H), .XW(XW), .YW(YW), .TIMEOUT(TO)) dut (
    .CLOCK(CLOCK), .RESET_n(RESET_n), .start(start), .abort(abort),
    .FVV(FVV), .LVV(LVV), .VCE(VCE), .red(red), .green(green), .blue(blue),
    .cam_enable(cam_enable), .cam_request(cam_request), .busy(busy), .done(done),
    .err_size(err_size), .err_timeout(err_timeout), .pix_valid(pix_valid),
    .pix_data(pix_data), .pix_x(pix_x), .pix_y(pix_y), .pix_sof(pix_sof), .pix_eof(pix_eof)
  );

  initial CLOCK = 1'b0;
  always #5 CLOCK = ~CLOCK;

  typedef struct packed {
    logic en, req, busy, done, es, et, pv, sof, eof;
    logic [23:0]   data;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
  } exp_t;

  exp_t nx, cur;
  int   vectors = 0, errors = 0;
  int   n_pix, n_sof, n_eof, n_done, n_busy;
  bit   chk_on = 1'b0;
  int   lens[$];

  always @(posedge CLOCK or negedge RESET_n)
    if (!RESET_n) cur <= '0;
    else          cur <= nx;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge CLOCK) if (chk_on) begin
    chk("cam_enable",  32'(cam_enable),  32'(cur.en));
    chk("cam_request", 32'(cam_request), 32'(cur.req));
    chk("busy",        32'(busy),        32'(cur.busy));
    chk("done",        32'(done),        32'(cur.done));
    chk("err_size",    32'(err_size),    32'(cur.es));
    chk("err_timeout", 32'(err_timeout), 32'(cur.et));
    chk("pix_valid",   32'(pix_valid),   32'(cur.pv));
    chk("pix_sof",     32'(pix_sof),     32'(cur.sof));
    chk("pix_eof",     32'(pix_eof),     32'(cur.eof));
    if (cur.pv) begin
      chk("pix_data", 32'(pix_data), 32'(cur.data));
      chk("pix_x",    32'(pix_x),    32'(cur.x));
      chk("pix_y",    32'(pix_y),    32'(cur.y));
    end
    if (pix_valid) n_pix++;
    if (pix_sof)   n_sof++;
    if (pix_eof)   n_eof++;
    if (done)      n_done++;
    if (busy)      n_busy++;
  end

  task automatic tick();
    @(posedge CLOCK);
    #1;
  endtask

  task automatic clear_counts();
    n_pix = 0; n_sof = 0; n_eof = 0; n_done = 0; n_busy = 0;
  endtask

  task automatic drive(input logic fv, input logic lv, input logic ve);
    logic [23:0] rgb;
    rgb = 24'($urandom);
    FVV = fv; LVV = lv; VCE = ve;
    {blue, green, red} = rgb;
    nx.req = 0; nx.done = 0; nx.pv = 0; nx.sof = 0; nx.eof = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      drive(0, 0, 0);
      start = 0; abort = 0;
      nx.en = 0; nx.busy = 0;
      tick();
    end
  endtask

  // One cycle spent waiting for a clean frame start; the TO-th one ends the capture.
  task automatic wait_cycle(inout int waited, inout bit to);
    waited++;
    if (waited == TO) begin
      nx.en = 0; nx.done = 1; nx.et = 1; to = 1;
    end
    tick();
  endtask

  task automatic kill(input bit use_reset);
    start = 0;
    if (use_reset) begin
      chk("enable_before_reset", 32'(cam_enable), 32'd1);
      RESET_n = 0;
      nx = '0;
      #1;
      chk("reset_ctrl", 32'({cam_enable, cam_request, busy, done, err_size, err_timeout,
                             pix_valid, pix_sof, pix_eof}), 32'd0);
      chk("reset_pix_xy", 32'({pix_x, pix_y}), 32'd0);
      chk("reset_pix_data", 32'(pix_data), 32'd0);
      drive(0, 0, 0);
      tick(); tick();
      RESET_n = 1;
    end else begin
      abort = 1;
      nx.en = 0; nx.busy = 0;
      tick();
      abort = 0;
    end
  endtask

  task automatic run_frame(input bit fv_high, input int sync_len, input int pre_wait,
                           input bit gaps, input int kill_at, input bit kill_reset,
                           input bit close_fv);
    int waited, bx, by, pix_n;
    bit to;
    waited = 0; bx = 0; by = 0; pix_n = 0; to = 0;
    drive(fv_high, 0, 0);
    start = 1;
    nx.en = 1; nx.busy = 1; nx.req = 1; nx.es = 0; nx.et = 0;
    tick();
    start = 0;
    drive(fv_high, 0, 0);
    tick();
    if (fv_high) begin
      for (int i = 0; i < sync_len && !to; i++) begin
        drive(1, 1'($urandom), 1'($urandom));
        wait_cycle(waited, to);
      end
      if (!to) begin drive(0, 0, 0); wait_cycle(waited, to); end
    end
    for (int i = 0; i < pre_wait && !to; i++) begin
      drive(0, 0, 0);
      wait_cycle(waited, to);
    end
    if (to) return;
    drive(1, 0, 0);
    tick();
    for (int l = 0; l < lens.size(); l++) begin
      repeat ($urandom_range(0, 1)) begin drive(1, 0, 0); tick(); end
      for (int p = 0; p < lens[l]; p++) begin
        if (gaps) repeat ($urandom_range(0, 2)) begin drive(1, 1, 0); tick(); end
        drive(1, 1, 1);
        if (pix_n == kill_at) begin kill(kill_reset); return; end
        start = ($urandom_range(0, 5) == 0);
        if (bx < W && by < H) begin
          nx.pv = 1; nx.data = {blue, green, red};
          nx.x = XW'(bx); nx.y = YW'(by);
          nx.sof = (bx == 0 && by == 0);
          nx.eof = (bx == W - 1 && by == H - 1);
        end else begin
          nx.es = 1;
        end
        if (bx < (1 << XW) - 1) bx++;
        pix_n++;
        tick();
        start = 0;
      end
      if (l != lens.size() - 1 || !close_fv) begin
        drive(1, 0, 0);
        if (bx != W) nx.es = 1;
        bx = 0;
        if (by < (1 << YW) - 1) by++;
        tick();
      end
    end
    drive(0, 0, 0);
    if (close_fv) begin
      if (bx != W) nx.es = 1;
      if (by < (1 << YW) - 1) by++;
    end
    if (by != H) nx.es = 1;
    nx.en = 0; nx.done = 1;
    tick();
  endtask

  initial begin
    int nl, pre, kl;
    RESET_n = 0; start = 0; abort = 0;
    FVV = 0; LVV = 0; VCE = 0; red = 0; green = 0; blue = 0;
    nx = '0;
    clear_counts();
    tick();
    chk_on = 1;
    tick();
    chk("reset_state", 32'({cam_enable, busy, done, err_size, err_timeout, pix_valid}), 32'd0);
    RESET_n = 1;
    idle(2);

    // Nominal 4x3 frame
    clear_counts();
    lens = {4, 4, 4};
    run_frame(0, 0, 2, 0, -1, 0, 0);
    idle(3);
    chk("nominal_pixels", 32'(n_pix), 32'd12);
    chk("nominal_sof", 32'(n_sof), 32'd1);
    chk("nominal_eof", 32'(n_eof), 32'd1);
    chk("nominal_done", 32'(n_done), 32'd1);
    chk("nominal_errs", 32'({err_size, err_timeout}), 32'd0);

    // Start while a frame is already in flight
    clear_counts();
    run_frame(1, 3, 1, 0, -1, 0, 1);
    idle(2);
    chk("midframe_pixels", 32'(n_pix), 32'd12);

    // Over-long first line, too few lines
    clear_counts();
    lens = {5, 4};
    run_frame(0, 0, 1, 0, -1, 0, 0);
    idle(2);
    chk("geom_pixels", 32'(n_pix), 32'd8);
    chk("geom_err", 32'(err_size), 32'd1);
    lens = {4, 4, 4};
    run_frame(0, 0, 1, 0, -1, 0, 0);
    idle(2);
    chk("geom_err_cleared", 32'(err_size), 32'd0);

    // Timeout with FVV held low
    clear_counts();
    run_frame(0, 0, 30, 0, -1, 0, 0);
    idle(3);
    chk("timeout_err", 32'(err_timeout), 32'd1);
    chk("timeout_busy_cycles", 32'(n_busy), 32'd22);
    chk("timeout_done", 32'(n_done), 32'd1);

    // VCE gaps between pixels
    clear_counts();
    run_frame(0, 0, 0, 1, -1, 0, 1);
    idle(2);
    chk("gaps_pixels", 32'(n_pix), 32'd12);
    chk("gaps_errs", 32'({err_size, err_timeout}), 32'd0);

    // Abort on line 2, then start+abort together in IDLE
    clear_counts();
    run_frame(0, 0, 1, 0, 5, 0, 0);
    chk("abort_busy", 32'(busy), 32'd0);
    idle(2);
    chk("abort_pixels", 32'(n_pix), 32'd5);
    chk("abort_no_done", 32'(n_done), 32'd0);
    clear_counts();
    drive(0, 0, 0);
    start = 1; abort = 1;
    nx.en = 0; nx.busy = 0;
    tick();
    idle(2);
    chk("start_abort_idle", 32'(n_busy), 32'd0);

    // Asynchronous reset mid-capture
    run_frame(0, 0, 1, 1, 6, 1, 0);
    idle(2);

    for (int it = 0; it < 60; it++) begin
      nl = $urandom_range(H - 1, H + 1);
      lens.delete();
      repeat (nl) lens.push_back(($urandom_range(0, 3) == 0) ? $urandom_range(W - 1, W + 1) : W);
      pre = ($urandom_range(0, 7) == 0) ? $urandom_range(15, 25) : $urandom_range(0, 4);
      kl  = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 12) : -1;
      run_frame(1'($urandom), $urandom_range(0, 3), pre, 1'($urandom), kl, 0, 1'($urandom));
      idle($urandom_range(1, 3));
    end

    chk_on = 0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
